// File: rtl/i2c_target_regfile_pkg.sv
// i2c_pkg: shared types and constants for the I2C target register file.
package i2c_pkg;

    // Target protocol states. The *_ACK states cover the ninth SCL period of a byte.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_IGNORE,
        ST_PTR,
        ST_PTR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK
    } i2c_tgt_state_t;

    // Level of SDA during the acknowledge bit.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_target_regfile_line_cond.sv
// i2c_line_cond: conditions one asynchronous I2C pad input.
// Two-flop synchroniser, optional spike filter (I2C_TGT_SPIKE_FILTER_EN),
// then one stage of history to produce single-clk rise/fall pulses.
module i2c_line_cond #(
    parameter int FILT_LEN = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic lvl;
    logic prev_q;

    // Synchroniser; resets to the idle-high bus level so no edge is seen at reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= line_i;
            sync_q <= meta_q;
        end
    end

`ifdef I2C_TGT_SPIKE_FILTER_EN
    localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    logic [CW-1:0] cnt_q;
    logic          filt_q;

    // Accept a new level only after it has differed from the filtered level for FILT_LEN clks.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            filt_q <= 1'b1;
        end else if (sync_q == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(FILT_LEN - 1)) begin
            cnt_q  <= '0;
            filt_q <= sync_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign lvl = filt_q;
`else
    // FILT_LEN only matters when the filter is built in.
    logic unused_filt_len;
    assign unused_filt_len = (FILT_LEN > 0);

    assign lvl = sync_q;
`endif

    // History stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= lvl;
        end
    end

    assign level_o = lvl;
    assign rise_o  = lvl & ~prev_q;
    assign fall_o  = ~lvl & prev_q;

endmodule

// File: rtl/i2c_target_regfile.sv
// i2c_target_regfile: I2C target with a pointer-addressed byte register file
// and a local SoC-side port onto the same storage.
// Optional SCL/SDA spike filter: define I2C_TGT_SPIKE_FILTER_EN.
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] TGT_ADDR = 7'h50,
    parameter int         DEPTH    = 16,
    parameter int         FILT_LEN = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     scl_i,
    input  logic                     sda_i,
    output logic                     sda_oe,
    input  logic [$clog2(DEPTH)-1:0] loc_addr,
    input  logic                     loc_we,
    input  logic [7:0]               loc_wdata,
    output logic [7:0]               loc_rdata,
    output logic                     wr_done,
    output logic                     busy
);

    localparam int AW = $clog2(DEPTH);

    logic scl_lvl, scl_rise, scl_fall;
    logic sda_lvl, sda_rise, sda_fall;
    logic start_det, stop_det, rx_done;

    i2c_tgt_state_t state_q, state_d;
    logic [3:0]     bitcnt_q, bitcnt_d;
    logic [7:0]     shreg_q, shreg_d;
    logic [AW-1:0]  ptr_q, ptr_d, ptr_inc;
    logic           sda_oe_q, sda_oe_d;
    logic           busy_q, busy_d;
    logic           wr_flag_q, wr_flag_d;
    logic           wr_done_q, wr_done_d;
    logic           rw_q, rw_d;
    logic           rf_we;
    logic [7:0]     regfile_q [DEPTH];

    i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_scl_cond (
        .clk     (clk),
        .rst     (rst),
        .line_i  (scl_i),
        .level_o (scl_lvl),
        .rise_o  (scl_rise),
        .fall_o  (scl_fall)
    );

    i2c_line_cond #(.FILT_LEN(FILT_LEN)) u_sda_cond (
        .clk     (clk),
        .rst     (rst),
        .line_i  (sda_i),
        .level_o (sda_lvl),
        .rise_o  (sda_rise),
        .fall_o  (sda_fall)
    );

    assign start_det = sda_fall & scl_lvl;
    assign stop_det  = sda_rise & scl_lvl;
    // Eight bits have been clocked in and SCL has just dropped: time to answer.
    assign rx_done   = scl_fall && (bitcnt_q == 4'd8);
    assign ptr_inc   = ptr_q + 1'b1;

    // Protocol FSM next-state logic; START/STOP override every state.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        shreg_d   = shreg_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_flag_d = wr_flag_q;
        wr_done_d = 1'b0;
        rw_d      = rw_q;
        rf_we     = 1'b0;

        if (start_det) begin
            state_d  = ST_ADDR;
            bitcnt_d = 4'd0;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
            wr_done_d = wr_flag_q;
            wr_flag_d = 1'b0;
        end else begin
            // Receive-side states all shift SDA in on SCL rise.
            if ((state_q == ST_ADDR || state_q == ST_PTR || state_q == ST_WDATA) && scl_rise) begin
                shreg_d  = {shreg_q[6:0], sda_lvl};
                bitcnt_d = bitcnt_q + 4'd1;
            end

            case (state_q)
                ST_ADDR: begin
                    if (rx_done) begin
                        bitcnt_d = 4'd0;
                        if (shreg_q[7:1] == TGT_ADDR) begin
                            sda_oe_d = 1'b1;
                            busy_d   = 1'b1;
                            rw_d     = shreg_q[0];
                            state_d  = ST_ADDR_ACK;
                            if (shreg_q[0]) begin
                                shreg_d = regfile_q[ptr_q];
                            end
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (rw_q) begin
                            // First read bit goes out on the same fall that ends the ACK.
                            sda_oe_d = ~shreg_q[7];
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            bitcnt_d = 4'd1;
                            state_d  = ST_RDATA;
                        end else begin
                            sda_oe_d = 1'b0;
                            bitcnt_d = 4'd0;
                            state_d  = ST_PTR;
                        end
                    end
                end
                ST_PTR: begin
                    if (rx_done) begin
                        sda_oe_d = 1'b1;
                        ptr_d    = shreg_q[AW-1:0];
                        state_d  = ST_PTR_ACK;
                    end
                end
                ST_WDATA: begin
                    if (rx_done) begin
                        sda_oe_d  = 1'b1;
                        rf_we     = 1'b1;
                        ptr_d     = ptr_inc;
                        wr_flag_d = 1'b1;
                        state_d   = ST_WDATA_ACK;
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        sda_oe_d = 1'b0;
                        bitcnt_d = 4'd0;
                        state_d  = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bitcnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            state_d  = ST_RDATA_ACK;
                        end else begin
                            sda_oe_d = ~shreg_q[7];
                            shreg_d  = {shreg_q[6:0], 1'b0};
                            bitcnt_d = bitcnt_q + 4'd1;
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise) begin
                        if (sda_lvl == I2C_NACK) begin
                            state_d = ST_IGNORE;
                        end else begin
                            ptr_d    = ptr_inc;
                            shreg_d  = regfile_q[ptr_inc];
                            bitcnt_d = 4'd0;
                            state_d  = ST_RDATA;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Protocol state registers.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= ST_IDLE;
            bitcnt_q  <= 4'd0;
            shreg_q   <= 8'h00;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_flag_q <= 1'b0;
            wr_done_q <= 1'b0;
            rw_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            shreg_q   <= shreg_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_flag_q <= wr_flag_d;
            wr_done_q <= wr_done_d;
            rw_q      <= rw_d;
        end
    end

    // Register file; the I2C write is issued last so it wins a same-index collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: this memory is reset because its all-zero contents are visible to both ports.
            for (int i = 0; i < DEPTH; i++) begin
                regfile_q[i] <= 8'h00;
            end
        end else begin
            if (loc_we) begin
                regfile_q[loc_addr] <= loc_wdata;
            end
            if (rf_we) begin
                regfile_q[ptr_q] <= shreg_q;
            end
        end
    end

    assign loc_rdata = regfile_q[loc_addr];
    assign sda_oe    = sda_oe_q;
    assign wr_done   = wr_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// tb_i2c_target_regfile: directed bench for i2c_target_regfile.
// Acts as the I2C master on an open-drain bus model and checks the local port.
module tb_i2c_target_regfile;
    import i2c_pkg::*;

    localparam int FILT_LEN = 3;
    localparam int Q        = 8;   // clk cycles per quarter SCL period
`ifdef I2C_TGT_SPIKE_FILTER_EN
    localparam int LAT = 3 + FILT_LEN;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        logic [3:0] addr;
        logic       we;
        logic [7:0] wdata;
        logic [7:0] exp;
    } loc_vec_t;

    logic       clk;
    logic       rst;
    logic       scl_m;
    logic       sda_m;
    logic       sda_bus;
    logic       sda_oe;
    logic [3:0] loc_addr;
    logic       loc_we;
    logic [7:0] loc_wdata;
    logic [7:0] loc_rdata;
    logic       wr_done;
    logic       busy;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    int oe_cnt = 0;
    int busy_cnt = 0;

    loc_vec_t vecs [6];

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_regfile #(
        .TGT_ADDR (7'h50),
        .DEPTH    (16),
        .FILT_LEN (FILT_LEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_m),
        .sda_i     (sda_bus),
        .sda_oe    (sda_oe),
        .loc_addr  (loc_addr),
        .loc_we    (loc_we),
        .loc_wdata (loc_wdata),
        .loc_rdata (loc_rdata),
        .wr_done   (wr_done),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (wr_done) wr_cnt <= wr_cnt + 1;
        if (sda_oe)  oe_cnt <= oe_cnt + 1;
        if (busy)    busy_cnt <= busy_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic loc_write(input logic [3:0] a, input logic [7:0] d);
        loc_addr  = a;
        loc_wdata = d;
        loc_we    = 1'b1;
        wait_clk(1);
        loc_we    = 1'b0;
    endtask

    task automatic loc_check(input string name, input logic [3:0] a, input logic [7:0] exp);
        loc_addr = a;
        #1;
        check(name, loc_rdata, exp);
    endtask

    // One SCL period; SDA changes mid-low, the bus is sampled mid-high.
    task automatic xfer_bit(input logic b, input logic glitch, output logic s);
        wait_clk(Q);
        sda_m = b;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        if (glitch) begin
            scl_m = 1'b0;
            wait_clk(2);
            scl_m = 1'b1;
            wait_clk(2);
        end
        s = sda_bus;
        wait_clk(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_start();
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b0;
    endtask

    task automatic i2c_stop();
        wait_clk(Q);
        sda_m = 1'b0;
        wait_clk(Q);
        scl_m = 1'b1;
        wait_clk(Q);
        sda_m = 1'b1;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, input logic glitch_msb, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(d[i], (i == 7) && glitch_msb, s);
        end
        xfer_bit(1'b1, 1'b0, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        xfer_bit(mack, 1'b0, s);
    endtask

    initial begin
        logic       a;
        logic       s;
        logic [7:0] d;
        int         wr0;
        int         oe0;
        int         busy0;
        logic [7:0] col;

        vecs[0] = '{4'd0,  1'b0, 8'h00, 8'h00};
        vecs[1] = '{4'd15, 1'b0, 8'h00, 8'h00};
        vecs[2] = '{4'd7,  1'b1, 8'hA5, 8'hA5};
        vecs[3] = '{4'd8,  1'b0, 8'h00, 8'h00};
        vecs[4] = '{4'd7,  1'b0, 8'h00, 8'hA5};
        vecs[5] = '{4'd9,  1'b1, 8'h3C, 8'h3C};

        rst = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
        loc_we = 1'b0; loc_addr = 4'd0; loc_wdata = 8'h00;
        wait_clk(4);
        check("rst_sda_oe", sda_oe, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_wr_done", wr_done, 1'b0);
        rst = 1'b0;
        wait_clk(4);

        // Local port table.
        for (int i = 0; i < 6; i++) begin
            loc_addr  = vecs[i].addr;
            loc_wdata = vecs[i].wdata;
            loc_we    = vecs[i].we;
            wait_clk(1);
            loc_we    = 1'b0;
            #1;
            check($sformatf("loc_vec%0d", i), loc_rdata, vecs[i].exp);
        end

        // Test 1: pointer write then two data bytes.
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, 1'b0, a); check("t1_addr_ack", a, I2C_ACK);
        check("t1_busy", busy, 1'b1);
        write_byte(8'h03, 1'b0, a); check("t1_ptr_ack", a, I2C_ACK);
        write_byte(8'h11, 1'b0, a); check("t1_d0_ack", a, I2C_ACK);
        write_byte(8'h22, 1'b0, a); check("t1_d1_ack", a, I2C_ACK);
        i2c_stop();
        wait_clk(2 * Q);
        check("t1_wr_done", wr_cnt - wr0, 1);
        check("t1_busy_end", busy, 1'b0);
        loc_check("t1_reg3", 4'd3, 8'h11);
        loc_check("t1_reg4", 4'd4, 8'h22);

        // Read with retained pointer (5 after the two writes).
        loc_write(4'd5, 8'h77);
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hA1, 1'b0, a); check("rp_addr_ack", a, I2C_ACK);
        read_byte(I2C_NACK, d);     check("rp_data", d, 8'h77);
        i2c_stop();
        wait_clk(2 * Q);
        check("rp_no_wr_done", wr_cnt - wr0, 0);

        // Test 2: pointer 0x0F, repeated START, read with wrap.
        loc_write(4'd15, 8'h5A);
        loc_write(4'd0, 8'hC3);
        wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hA0, 1'b0, a); check("t2_addr_ack", a, I2C_ACK);
        write_byte(8'h0F, 1'b0, a); check("t2_ptr_ack", a, I2C_ACK);
        i2c_start();
        write_byte(8'hA1, 1'b0, a); check("t2_raddr_ack", a, I2C_ACK);
        read_byte(I2C_ACK, d);      check("t2_byte0", d, 8'h5A);
        check("t2_busy", busy, 1'b1);
        read_byte(I2C_NACK, d);     check("t2_byte1_wrap", d, 8'hC3);
        i2c_stop();
        wait_clk(2 * Q);
        check("t2_no_wr_done", wr_cnt - wr0, 0);

        // Test 3: foreign address is ignored.
        oe0 = oe_cnt; busy0 = busy_cnt; wr0 = wr_cnt;
        i2c_start();
        write_byte(8'hA2, 1'b0, a); check("t3_addr_nack", a, I2C_NACK);
        write_byte(8'h03, 1'b0, a); check("t3_b0_nack", a, I2C_NACK);
        write_byte(8'h99, 1'b0, a); check("t3_b1_nack", a, I2C_NACK);
        i2c_stop();
        wait_clk(2 * Q);
        check("t3_oe_never", oe_cnt - oe0, 0);
        check("t3_busy_never", busy_cnt - busy0, 0);
        check("t3_no_wr_done", wr_cnt - wr0, 0);
        loc_check("t3_reg3", 4'd3, 8'h11);

        // Test 4: local and I2C write hit index 5 on the same clk.
        wr0 = wr_cnt;
        col = 8'h01;
        i2c_start();
        write_byte(8'hA0, 1'b0, a); check("t4_addr_ack", a, I2C_ACK);
        write_byte(8'h05, 1'b0, a); check("t4_ptr_ack", a, I2C_ACK);
        for (int i = 7; i >= 0; i--) begin
            xfer_bit(col[i], 1'b0, s);
        end
        wait_clk(LAT - 1);
        loc_addr = 4'd5; loc_wdata = 8'hFF; loc_we = 1'b1;
        wait_clk(1);
        loc_we = 1'b0;
        xfer_bit(1'b1, 1'b0, a);    check("t4_data_ack", a, I2C_ACK);
        i2c_stop();
        wait_clk(2 * Q);
        loc_check("t4_reg5", 4'd5, 8'h01);
        check("t4_wr_done", wr_cnt - wr0, 1);

        // Test 5: reset while the target drives a 0 in RDATA.
        loc_write(4'd2, 8'h3C);
        i2c_start();
        write_byte(8'hA0, 1'b0, a); check("t5_addr_ack", a, I2C_ACK);
        write_byte(8'h02, 1'b0, a); check("t5_ptr_ack", a, I2C_ACK);
        i2c_start();
        write_byte(8'hA1, 1'b0, a); check("t5_raddr_ack", a, I2C_ACK);
        wait_clk(LAT + 2);
        check("t5_driving0", sda_oe, 1'b1);
        rst = 1'b1;
        wait_clk(1);
        check("t5_rst_release", sda_oe, 1'b0);
        check("t5_rst_busy", busy, 1'b0);
        wait_clk(1);
        rst = 1'b0;
        wait_clk(2);
        loc_check("t5_reg3_cleared", 4'd3, 8'h00);
        loc_write(4'd0, 8'h81);
        i2c_start();
        write_byte(8'hA0, 1'b0, a); check("t5_new_ack", a, I2C_ACK);
        i2c_stop();
        i2c_start();
        write_byte(8'hA1, 1'b0, a); check("t5_rd_ack", a, I2C_ACK);
        read_byte(I2C_NACK, d);     check("t5_ptr_zero", d, 8'h81);
        i2c_stop();
        wait_clk(2 * Q);

        // Test 6: 2-clk low glitch on SCL high during the address MSB.
        i2c_start();
        write_byte(8'hA0, 1'b1, a);
`ifdef I2C_TGT_SPIKE_FILTER_EN
        check("t6_glitch_filtered", a, I2C_ACK);
`else
        check("t6_glitch_counted", a, I2C_NACK);
`endif
        i2c_stop();
        wait_clk(2 * Q);
        check("t6_idle_oe", sda_oe, 1'b0);
        check("t6_idle_busy", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
